// File: rtl/dffram_arb_pkg.sv
// Shared types and defaults for the DFFRAM instruction/data arbiter.
// Response owner encoding, default geometry and the address-window test.
package dffram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  localparam int unsigned AW_DEFAULT        = 12;
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0000_0000;

  // True when addr lies in [base, base + 4*2**aw); the 33-bit offset catches addr < base.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int unsigned aw);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, base};
    return !off[32] && ((off[31:0] >> (aw + 2)) == 32'd0);
  endfunction

endpackage

// File: rtl/dffram_arb_rr.sv
// Two-input round-robin picker; the pointer names the port that won the last conflict.
module dffram_arb_rr
  import dffram_arb_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   req_instr_i,
  input  logic   req_data_i,
  output logic   gnt_instr_o,
  output logic   gnt_data_o,
  output owner_e last_conflict_port_o
);

  owner_e last_q, last_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= OWN_INSTR;
    end else begin
      last_q <= last_d;
    end
  end

  // Pointer moves only when both ports compete; lone requests leave it untouched.
  always_comb begin
    gnt_instr_o = 1'b0;
    gnt_data_o  = 1'b0;
    last_d      = last_q;
    if (req_instr_i && req_data_i) begin
      if (last_q == OWN_INSTR) begin
        gnt_data_o = 1'b1;
        last_d     = OWN_DATA;
      end else begin
        gnt_instr_o = 1'b1;
        last_d      = OWN_INSTR;
      end
    end else begin
      gnt_instr_o = req_instr_i;
      gnt_data_o  = req_data_i;
    end
  end

  assign last_conflict_port_o = last_q;

endmodule

// File: rtl/dffram_arbiter.sv
// Shares one single-port DFFRAM between an instruction and a data port, one access per cycle.
// Define DFFRAM_ARB_RANGE_CHECK_EN to error out-of-window accesses instead of aliasing them.
module dffram_arbiter
  import dffram_arb_pkg::*;
#(
  parameter int unsigned AW        = AW_DEFAULT,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          instr_req_i,
  input  logic [31:0]   instr_addr_i,
  output logic          instr_gnt_o,
  output logic          instr_rvalid_o,
  output logic [31:0]   instr_rdata_o,
  output logic          instr_err_o,
  input  logic          data_req_i,
  input  logic          data_we_i,
  input  logic [3:0]    data_be_i,
  input  logic [31:0]   data_addr_i,
  input  logic [31:0]   data_wdata_i,
  output logic          data_gnt_o,
  output logic          data_rvalid_o,
  output logic [31:0]   data_rdata_o,
  output logic          data_err_o,
  output logic          ram_en_o,
  output logic [3:0]    ram_we_o,
  output logic [AW-1:0] ram_a_o,
  output logic [31:0]   ram_di_o,
  input  logic [31:0]   ram_do_i
);

  // Handshake: gnt is combinational with req; a granted request gets exactly one
  // rvalid on the following cycle; an ungranted requester holds its request stable.

  logic   gnt_instr, gnt_data;
  logic   instr_in, data_in;
  owner_e owner_q, owner_d;
  logic   rd_q, rd_d;
  owner_e last_conflict_port;
  logic   unused_bits;

  dffram_arb_rr u_rr (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .req_instr_i          (instr_req_i & rst_ni),
    .req_data_i           (data_req_i & rst_ni),
    .gnt_instr_o          (gnt_instr),
    .gnt_data_o           (gnt_data),
    .last_conflict_port_o (last_conflict_port)
  );

`ifdef DFFRAM_ARB_RANGE_CHECK_EN
  logic err_q, err_d;
  assign instr_in = in_window(instr_addr_i, BASE_ADDR, AW);
  assign data_in  = in_window(data_addr_i, BASE_ADDR, AW);
  assign err_d    = (gnt_instr && !instr_in) || (gnt_data && !data_in);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign instr_err_o = (owner_q == OWN_INSTR) && err_q;
  assign data_err_o  = (owner_q == OWN_DATA) && err_q;
`else
  assign instr_in    = 1'b1;
  assign data_in     = 1'b1;
  assign instr_err_o = 1'b0;
  assign data_err_o  = 1'b0;
`endif

  always_comb begin
    ram_en_o = 1'b0;
    ram_we_o = 4'b0000;
    ram_a_o  = '0;
    ram_di_o = 32'h0;
    owner_d  = OWN_NONE;
    rd_d     = 1'b0;
    if (gnt_instr) begin
      ram_en_o = instr_in;
      ram_a_o  = instr_addr_i[AW+1:2];
      owner_d  = OWN_INSTR;
      rd_d     = instr_in;
    end else if (gnt_data) begin
      ram_en_o = data_in;
      ram_a_o  = data_addr_i[AW+1:2];
      owner_d  = OWN_DATA;
      rd_d     = data_in && !data_we_i;
      if (data_in && data_we_i) begin
        ram_we_o = data_be_i;
        ram_di_o = data_wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q <= OWN_NONE;
      rd_q    <= 1'b0;
    end else begin
      owner_q <= owner_d;
      rd_q    <= rd_d;
    end
  end

  assign instr_gnt_o    = gnt_instr;
  assign data_gnt_o     = gnt_data;
  assign instr_rvalid_o = (owner_q == OWN_INSTR);
  assign data_rvalid_o  = (owner_q == OWN_DATA);
  assign instr_rdata_o  = (instr_rvalid_o && rd_q) ? ram_do_i : 32'h0;
  assign data_rdata_o   = (data_rvalid_o && rd_q) ? ram_do_i : 32'h0;

  // Address bits above the window and the pointer are observed only in some builds.
  assign unused_bits = ^{instr_addr_i, data_addr_i, BASE_ADDR, last_conflict_port};

endmodule

// File: tb/tb_dffram_arbiter.sv
// Directed bench for dffram_arbiter with a 1-cycle registered RAM model.
// Build with DFFRAM_ARB_RANGE_CHECK_EN to exercise the out-of-window error path.
module tb_dffram_arbiter;

  localparam int unsigned AW = 12;

  logic          clk;
  logic          rst_ni;
  logic          instr_req, instr_gnt, instr_rvalid, instr_err;
  logic [31:0]   instr_addr, instr_rdata;
  logic          data_req, data_we, data_gnt, data_rvalid, data_err;
  logic [3:0]    data_be;
  logic [31:0]   data_addr, data_wdata, data_rdata;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_a;
  logic [31:0]   ram_di, ram_do;

  logic [31:0]   mem [0:(1<<AW)-1];

  int n_pass;
  int n_total;

  dffram_arbiter #(.AW(AW), .BASE_ADDR(32'h0000_0000)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .instr_req_i    (instr_req),
    .instr_addr_i   (instr_addr),
    .instr_gnt_o    (instr_gnt),
    .instr_rvalid_o (instr_rvalid),
    .instr_rdata_o  (instr_rdata),
    .instr_err_o    (instr_err),
    .data_req_i     (data_req),
    .data_we_i      (data_we),
    .data_be_i      (data_be),
    .data_addr_i    (data_addr),
    .data_wdata_i   (data_wdata),
    .data_gnt_o     (data_gnt),
    .data_rvalid_o  (data_rvalid),
    .data_rdata_o   (data_rdata),
    .data_err_o     (data_err),
    .ram_en_o       (ram_en),
    .ram_we_o       (ram_we),
    .ram_a_o        (ram_a),
    .ram_di_o       (ram_di),
    .ram_do_i       (ram_do)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered read, byte-masked write
  always @(posedge clk) begin
    if (ram_en) begin
      ram_do <= mem[ram_a];
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic drive_idle();
    instr_req  = 1'b0;
    instr_addr = 32'h0;
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_be    = 4'h0;
    data_addr  = 32'h0;
    data_wdata = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    ram_do  = 32'h0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    mem[0] = 32'h0000_5A5A;
    mem[2] = 32'hAABB_CCDD;
    mem[4] = 32'hDEAD_BEEF;

    // Reset with both ports requesting: everything must stay 0
    rst_ni     = 1'b0;
    instr_req  = 1'b1;
    instr_addr = 32'h10;
    data_req   = 1'b1;
    data_we    = 1'b1;
    data_be    = 4'hF;
    data_addr  = 32'h8;
    data_wdata = 32'hFFFF_FFFF;
    @(negedge clk); #1;
    chk("rst_instr_gnt", {31'h0, instr_gnt}, 32'h0);
    chk("rst_data_gnt", {31'h0, data_gnt}, 32'h0);
    chk("rst_ram_en", {31'h0, ram_en}, 32'h0);
    chk("rst_ram_we", {28'h0, ram_we}, 32'h0);
    chk("rst_ram_a", {20'h0, ram_a}, 32'h0);
    chk("rst_ram_di", ram_di, 32'h0);
    chk("rst_rvalid", {30'h0, instr_rvalid, data_rvalid}, 32'h0);
    chk("rst_rdata", instr_rdata | data_rdata, 32'h0);
    chk("rst_err", {30'h0, instr_err, data_err}, 32'h0);
    @(negedge clk);
    drive_idle();
    rst_ni = 1'b1;
    #1;
    chk("idle_ram_en", {31'h0, ram_en}, 32'h0);
    chk("idle_ram_a", {20'h0, ram_a}, 32'h0);

    // Instruction-only fetch of word 4
    @(negedge clk);
    instr_req  = 1'b1;
    instr_addr = 32'h10;
    #1;
    chk("if_gnt", {31'h0, instr_gnt}, 32'h1);
    chk("if_data_gnt", {31'h0, data_gnt}, 32'h0);
    chk("if_ram_en", {31'h0, ram_en}, 32'h1);
    chk("if_ram_a", {20'h0, ram_a}, 32'h4);
    chk("if_ram_we", {28'h0, ram_we}, 32'h0);
    @(negedge clk);
    drive_idle();
    #1;
    chk("if_rvalid", {31'h0, instr_rvalid}, 32'h1);
    chk("if_rdata", instr_rdata, 32'hDEAD_BEEF);
    chk("if_data_rvalid", {31'h0, data_rvalid}, 32'h0);
    chk("if_err", {31'h0, instr_err}, 32'h0);
    @(negedge clk); #1;
    chk("if_rvalid_once", {31'h0, instr_rvalid}, 32'h0);
    chk("if_rdata_idle", instr_rdata, 32'h0);

    // Data store to word 2 with bytes 0 and 2 enabled
    @(negedge clk);
    data_req   = 1'b1;
    data_we    = 1'b1;
    data_be    = 4'b0101;
    data_addr  = 32'h8;
    data_wdata = 32'h1122_3344;
    #1;
    chk("st_gnt", {31'h0, data_gnt}, 32'h1);
    chk("st_ram_we", {28'h0, ram_we}, 32'h5);
    chk("st_ram_a", {20'h0, ram_a}, 32'h2);
    chk("st_ram_di", ram_di, 32'h1122_3344);
    @(negedge clk);
    drive_idle();
    #1;
    chk("st_rvalid", {31'h0, data_rvalid}, 32'h1);
    chk("st_rdata", data_rdata, 32'h0);
    chk("st_idle_we", {28'h0, ram_we}, 32'h0);
    chk("st_idle_di", ram_di, 32'h0);
    @(negedge clk);
    data_req  = 1'b1;
    data_addr = 32'h8;
    #1;
    chk("ld_ram_we", {28'h0, ram_we}, 32'h0);
    @(negedge clk);
    drive_idle();
    #1;
    chk("ld_rvalid", {31'h0, data_rvalid}, 32'h1);
    chk("ld_rdata", data_rdata, 32'hAA22_CC44);

    // Continuous conflict from reset: data, instr, data, instr
    do_reset();
    @(negedge clk);
    instr_req  = 1'b1;
    instr_addr = 32'h10;
    data_req   = 1'b1;
    data_addr  = 32'h8;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("cf%0d_data_gnt", i), {31'h0, data_gnt}, (i % 2 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("cf%0d_instr_gnt", i), {31'h0, instr_gnt}, (i % 2 == 1) ? 32'h1 : 32'h0);
      chk($sformatf("cf%0d_ram_a", i), {20'h0, ram_a}, (i % 2 == 0) ? 32'h2 : 32'h4);
      if (i == 1 || i == 3) begin
        chk($sformatf("cf%0d_data_rvalid", i), {31'h0, data_rvalid}, 32'h1);
        chk($sformatf("cf%0d_data_rdata", i), data_rdata, 32'hAA22_CC44);
        chk($sformatf("cf%0d_instr_rvalid", i), {31'h0, instr_rvalid}, 32'h0);
      end
      if (i == 2) begin
        chk("cf2_instr_rvalid", {31'h0, instr_rvalid}, 32'h1);
        chk("cf2_instr_rdata", instr_rdata, 32'hDEAD_BEEF);
        chk("cf2_data_rdata", data_rdata, 32'h0);
      end
      @(negedge clk);
    end
    drive_idle();
    #1;
    chk("cf_tail_instr_rvalid", {31'h0, instr_rvalid}, 32'h1);
    chk("cf_tail_instr_rdata", instr_rdata, 32'hDEAD_BEEF);
    chk("cf_tail_data_rvalid", {31'h0, data_rvalid}, 32'h0);

    // Lone data grant must not move the pointer: data still wins next conflict
    @(negedge clk);
    data_req  = 1'b1;
    data_addr = 32'h8;
    #1;
    chk("solo_data_gnt", {31'h0, data_gnt}, 32'h1);
    @(negedge clk);
    instr_req  = 1'b1;
    instr_addr = 32'h10;
    #1;
    chk("ptr_data_gnt", {31'h0, data_gnt}, 32'h1);
    chk("ptr_instr_gnt", {31'h0, instr_gnt}, 32'h0);
    @(negedge clk);
    data_req = 1'b0;
    #1;
    chk("ptr_instr_late_gnt", {31'h0, instr_gnt}, 32'h1);
    @(negedge clk);
    drive_idle();
    #1;
    chk("ptr_instr_rdata", instr_rdata, 32'hDEAD_BEEF);

    // Reset in the response cycle drops the pending response
    @(negedge clk);
    instr_req  = 1'b1;
    instr_addr = 32'h10;
    #1;
    chk("rr_gnt", {31'h0, instr_gnt}, 32'h1);
    @(posedge clk); #1;
    rst_ni = 1'b0;
    #1;
    chk("rr_rvalid", {30'h0, instr_rvalid, data_rvalid}, 32'h0);
    chk("rr_rdata", instr_rdata, 32'h0);
    chk("rr_gnt_in_rst", {31'h0, instr_gnt}, 32'h0);
    chk("rr_ram_en", {31'h0, ram_en}, 32'h0);
    @(negedge clk);
    drive_idle();
    rst_ni = 1'b1;
    #1;
    chk("rr_post_rvalid", {30'h0, instr_rvalid, data_rvalid}, 32'h0);
    @(negedge clk); #1;
    chk("rr_post2_rvalid", {30'h0, instr_rvalid, data_rvalid}, 32'h0);
    chk("rr_post2_ram", {ram_en, ram_we, ram_a, 15'h0}, 32'h0);

    // Read just past the 16 KiB window
    @(negedge clk);
    data_req  = 1'b1;
    data_addr = 32'h4000;
    #1;
    chk("oor_gnt", {31'h0, data_gnt}, 32'h1);
`ifdef DFFRAM_ARB_RANGE_CHECK_EN
    chk("oor_ram_en", {31'h0, ram_en}, 32'h0);
    chk("oor_ram_we", {28'h0, ram_we}, 32'h0);
    @(negedge clk);
    drive_idle();
    #1;
    chk("oor_rvalid", {31'h0, data_rvalid}, 32'h1);
    chk("oor_err", {31'h0, data_err}, 32'h1);
    chk("oor_rdata", data_rdata, 32'h0);
    @(negedge clk); #1;
    chk("oor_err_clear", {31'h0, data_err}, 32'h0);
`else
    chk("alias_ram_en", {31'h0, ram_en}, 32'h1);
    chk("alias_ram_a", {20'h0, ram_a}, 32'h0);
    @(negedge clk);
    drive_idle();
    #1;
    chk("alias_rvalid", {31'h0, data_rvalid}, 32'h1);
    chk("alias_err", {31'h0, data_err}, 32'h0);
    chk("alias_rdata", data_rdata, 32'h0000_5A5A);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
